add_lod_pipe: RTL and testbench

//  Parametrised, pipelined leading-one / leading-sign normaliser for the FP add datapath.

---
 rtl/add_lod_pipe.sv | 138 +++++++++++++
 tb/tb_add_lod_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_lod_pipe.sv
// add_lod_pipe: pipelined leading-one / leading-sign normaliser; optional sideband via ADD_LOD_PIPE_SIDEBAND_EN.
// Latency: NS = ceil($clog2(INPUT_WIDTH)/REG_EVERY) cycles, 1 word/cycle.
// Backpressure: valid/ready per stage, empty stages fill under stall, in_ready = !vld0 || rdy0.
module add_lod_pipe #(
    parameter int INPUT_WIDTH = 48,
    parameter int REG_EVERY   = 2
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
    ,
    parameter int SB_WIDTH    = 8
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INPUT_WIDTH-1:0]           in_detect,
    input  logic                             in_mode,
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
    input  logic [SB_WIDTH-1:0]              in_sb,
    output logic [SB_WIDTH-1:0]              out_sb,
`endif
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(INPUT_WIDTH+1)-1:0] zero_nums,
    output logic [INPUT_WIDTH-1:0]           out_shift,
    output logic                             all_zero
);

    localparam int W  = INPUT_WIDTH;
    localparam int L  = $clog2(W);
    localparam int NS = (L + REG_EVERY - 1) / REG_EVERY;
    localparam int ZW = $clog2(W + 1);
    localparam logic [W-1:0] ONES = '1;

    // Per-word payload carried through the shift tree.
    typedef struct packed {
        logic [W-1:0]        dat;
        logic [ZW-1:0]       cnt;
        logic                mode;
        logic                az;
        logic                sgn;
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
        logic [SB_WIDTH-1:0] sb;
`endif
    } stg_t;

    stg_t          stg_in;
    stg_t          stg_up  [NS];
    stg_t          stg_q   [NS];
    logic [NS-1:0] stg_vld;
    logic [NS-1:0] up_vld;
    logic [NS-1:0] stg_ld;

    // Degenerate words are flagged up front; the tree alone would overshoot their count.
    always_comb begin
        stg_in      = '0;
        stg_in.dat  = in_detect;
        stg_in.mode = in_mode;
        stg_in.sgn  = in_detect[W-1];
        stg_in.az   = in_mode ? ((&in_detect) || (~|in_detect)) : (~|in_detect);
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
        stg_in.sb   = in_sb;
`endif
    end

    always_comb begin
        up_vld[0] = in_valid;
        stg_up[0] = stg_in;
        for (int k = 1; k < NS; k++) begin
            up_vld[k] = stg_vld[k-1];
            stg_up[k] = stg_q[k-1];
        end
    end

    // Ready ripples back from the output so bubbles collapse under stall.
    always_comb begin
        logic r;
        r = out_ready;
        for (int k = NS - 1; k >= 0; k--) begin
            stg_ld[k] = !stg_vld[k] || r;
            r         = stg_ld[k];
        end
    end

    assign in_ready = stg_ld[0];

    for (genvar k = 0; k < NS; k++) begin : g_stg
        localparam int HI = L - 1 - k * REG_EVERY;
        localparam int LO = (HI - REG_EVERY + 1 > 0) ? (HI - REG_EVERY + 1) : 0;

        stg_t         nxt;
        stg_t         q;
        logic         vld;
        logic [W-1:0] msk;

        // Mode 1 compares one extra bit so the sign bit itself is kept.
        always_comb begin
            nxt = stg_up[k];
            msk = '0;
            for (int j = HI; j >= LO; j--) begin
                msk = nxt.mode ? ~(ONES >> ((1 << j) + 1)) : ~(ONES >> (1 << j));
                if (((nxt.dat & msk) == '0) || (nxt.mode && ((nxt.dat & msk) == msk))) begin
                    nxt.dat    = nxt.dat << (1 << j);
                    nxt.cnt[j] = 1'b1;
                end
            end
            if ((k == NS - 1) && nxt.az) begin
                nxt.cnt        = nxt.mode ? ZW'(W - 1) : ZW'(W);
                nxt.dat        = '0;
                nxt.dat[W-1]   = nxt.mode & nxt.sgn;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                q   <= '0;
            end else if (stg_ld[k]) begin
                vld <= up_vld[k];
                if (up_vld[k]) begin
                    q <= nxt;
                end
            end
        end

        assign stg_q[k]   = q;
        assign stg_vld[k] = vld;
    end

    assign out_valid = stg_vld[NS-1];
    assign zero_nums = stg_q[NS-1].cnt;
    assign out_shift = stg_q[NS-1].dat;
    assign all_zero  = stg_q[NS-1].az;
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
    assign out_sb    = stg_q[NS-1].sb;
`endif

endmodule

// File: tb/tb_add_lod_pipe.sv
// Directed bench for add_lod_pipe at W=8, REG_EVERY=1 (three register stages).
module tb_add_lod_pipe;

    localparam int W  = 8;
    localparam int ZW = 4;
    localparam int NV = 12;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_detect = '0;
    logic          in_mode   = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [ZW-1:0] zero_nums;
    logic [W-1:0]  out_shift;
    logic          all_zero;
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
    logic [7:0]    in_sb     = '0;
    logic [7:0]    out_sb;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]    v_dat  [NV];
    logic          v_mode [NV];
    logic [ZW-1:0] v_zn   [NV];
    logic [7:0]    v_sh   [NV];
    logic          v_az   [NV];
    logic [7:0]    v_sb   [NV];

    add_lod_pipe #(
        .INPUT_WIDTH (W),
        .REG_EVERY   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_detect (in_detect),
        .in_mode   (in_mode),
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
        .in_sb     (in_sb),
        .out_sb    (out_sb),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero_nums (zero_nums),
        .out_shift (out_shift),
        .all_zero  (all_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [7:0] d, input logic m,
                           input logic [ZW-1:0] zn, input logic [7:0] sh, input logic az);
        v_dat[i]  = d;
        v_mode[i] = m;
        v_zn[i]   = zn;
        v_sh[i]   = sh;
        v_az[i]   = az;
    endtask

    task automatic drive(input int i);
        in_detect = v_dat[i];
        in_mode   = v_mode[i];
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
        in_sb     = v_sb[i];
`endif
    endtask

    task automatic check_out(input int i);
        check($sformatf("zero_nums[%0d]", i), 32'(zero_nums), 32'(v_zn[i]));
        check($sformatf("out_shift[%0d]", i), 32'(out_shift), 32'(v_sh[i]));
        check($sformatf("all_zero[%0d]", i),  32'(all_zero),  32'(v_az[i]));
`ifdef ADD_LOD_PIPE_SIDEBAND_EN
        check($sformatf("out_sb[%0d]", i),    32'(out_sb),    32'(v_sb[i]));
`endif
    endtask

    // One isolated word: checks exact three-cycle latency and a clean drain.
    task automatic send_one(input int i);
        drive(i);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check($sformatf("accept_rdy[%0d]", i), 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check($sformatf("lat_early[%0d]", i), 32'(out_valid), 32'd0);
        tick();
        check($sformatf("lat_vld[%0d]", i), 32'(out_valid), 32'd1);
        check_out(i);
        tick();
        check($sformatf("lat_drain[%0d]", i), 32'(out_valid), 32'd0);
    endtask

    task automatic run_stream(input int first, input int count, input int st_from,
                              input int st_to, input bit rnd, input int budget);
        int            tx;
        int            rx;
        logic          acc;
        logic          held;
        logic [ZW-1:0] h_zn;
        logic [W-1:0]  h_sh;
        tx   = 0;
        rx   = 0;
        held = 1'b0;
        h_zn = '0;
        h_sh = '0;
        for (int cyc = 0; cyc < budget && rx < count; cyc++) begin
            if (tx < count) begin
                drive(first + tx);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st_from && cyc < st_to);
            #2;
            if (held) begin
                check("hold_vld", 32'(out_valid), 32'd1);
                check("hold_zn",  32'(zero_nums), 32'(h_zn));
                check("hold_sh",  32'(out_shift), 32'(h_sh));
            end
            if (st_to > st_from && cyc == st_to - 1) begin
                check("stall_accepted", 32'(tx), 32'd3);
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (st_to > st_from && cyc == st_to) begin
                check("pushpop_full", {30'd0, in_valid && in_ready, out_valid && out_ready}, 32'd3);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check_out(first + rx);
                rx++;
            end
            held = out_valid && !out_ready;
            h_zn = zero_nums;
            h_sh = out_shift;
            @(posedge clk);
            #1;
            if (acc) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(rx), 32'(count));
        repeat (4) tick();
        check("stream_no_extra", 32'(out_valid), 32'd0);
    endtask

    initial begin
        set_vec(0,  8'h16, 1'b0, 4'd3, 8'hB0, 1'b0);
        set_vec(1,  8'hE5, 1'b1, 4'd2, 8'h94, 1'b0);
        set_vec(2,  8'h03, 1'b1, 4'd5, 8'h60, 1'b0);
        set_vec(3,  8'h00, 1'b0, 4'd8, 8'h00, 1'b1);
        set_vec(4,  8'hFF, 1'b1, 4'd7, 8'h80, 1'b1);
        set_vec(5,  8'h80, 1'b0, 4'd0, 8'h80, 1'b0);
        set_vec(6,  8'h40, 1'b1, 4'd0, 8'h40, 1'b0);
        set_vec(7,  8'h01, 1'b0, 4'd7, 8'h80, 1'b0);
        set_vec(8,  8'h00, 1'b1, 4'd7, 8'h00, 1'b1);
        set_vec(9,  8'hFF, 1'b0, 4'd0, 8'hFF, 1'b0);
        set_vec(10, 8'hFE, 1'b1, 4'd6, 8'h80, 1'b0);
        set_vec(11, 8'h3C, 1'b0, 4'd2, 8'hF0, 1'b0);
        for (int i = 0; i < NV; i++) v_sb[i] = 8'((i * 8'h11) ^ 8'h5A);
        v_sb[0] = 8'hA5;
        v_sb[1] = 8'h3C;

        // Reset state
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_zero_nums", 32'(zero_nums), 32'd0);
        check("rst_out_shift", 32'(out_shift), 32'd0);
        check("rst_all_zero",  32'(all_zero),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single words: leading-one, leading-sign and degenerate inputs
        send_one(0);
        send_one(1);
        send_one(2);
        send_one(3);
        send_one(4);

        // Back-to-back mixed modes at full rate
        run_stream(0, 12, 0, 0, 1'b0, 15);

        // Six words, output stalled from cycle 2 to 9
        run_stream(0, 6, 2, 10, 1'b0, 60);

        // Reset with three words in flight
        out_ready = 1'b1;
        for (int i = 5; i < 8; i++) begin
            drive(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_vld", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_zero_nums", 32'(zero_nums), 32'd0);
        check("midrst_out_shift", 32'(out_shift), 32'd0);
        check("midrst_all_zero",  32'(all_zero),  32'd0);
        tick();
        tick();
        check("rst_hold_vld", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_vld", 32'(out_valid), 32'd0);
        send_one(11);

        // Random downstream back-pressure
        run_stream(0, 12, 0, 0, 1'b1, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
